display_arbiter: RTL
====================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter DWELL, default 1024, number of SHOW cycles per granted display slot, legal range 1..2^26-1.
REQ-002 Port clk  input  1  single clock, rising-edge active.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  3  per-requester display request; req[i] belongs to requester i.
REQ-005 Port req_data0, req_data1, req_data2  input  16 each  value requester i wants displayed.
REQ-006 Port freeze  input  1  when high, pauses the dwell countdown so the shown value is held.
REQ-007 Port grant  output  3  one-hot, identifies the requester currently owning the display; 000 when none.
REQ-008 Port ack  output  3  one-cycle pulse on ack[i] when requester i's slot completes normally.
REQ-009 Port disp_data  output  16  value driven to the 4-digit hex display data input.
REQ-010 Port disp_en  output  1  high while a granted value is being shown; low means blank.
REQ-011 Port busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHOW and DONE; all outputs are registered.
REQ-013 IDLE: if any req bit is high, the block SHALL select one requester round-robin, set grant one-hot, latch that requester's req_data into disp_data, clear the dwell counter and go to SHOW on the same edge.
REQ-014 Round-robin: the search SHALL start at the pointer index and go upward modulo 3; the pointer SHALL be 0 after reset.
REQ-015 Req-to-grant latency SHALL be one clock edge; disp_data and disp_en SHALL update on the same edge as grant.
REQ-016 disp_data SHALL hold the value latched at grant for the whole slot; req_data changes during SHOW SHALL NOT be reflected.
REQ-017 SHOW: disp_en=1; the counter SHALL increment each cycle freeze=0 and SHALL hold while freeze=1.
REQ-018 SHOW: when the counter equals DWELL-1 and freeze=0, the FSM SHALL go to DONE; SHOW therefore lasts exactly DWELL unfrozen cycles.
REQ-019 Abort: if req[g] of the granted requester is low in any SHOW cycle, the FSM SHALL go to IDLE on the next edge with grant=000 and disp_en=0, with no ack; the pointer SHALL become g+1 mod 3.
REQ-020 Abort takes priority over freeze and over dwell completion in the same cycle.
REQ-021 DONE: ack[g]=1 for exactly one cycle, grant=000, disp_en=0, pointer=g+1 mod 3; next state IDLE unconditionally.
REQ-022 disp_data SHALL retain its last value in DONE and IDLE until the next grant.
REQ-023 A requester holding req through DONE SHALL be re-eligible in IDLE at lowest priority; with req=111 continuously, the grant order SHALL be 001, 010, 100, 001, ...
REQ-024 Minimum spacing between consecutive grants SHALL be DWELL+2 cycles (SHOW x DWELL, DONE, IDLE).
REQ-025 The dwell counter SHALL be 26 bits wide; it never wraps because it is cleared at each grant.

Reset
REQ-026 While reset=0, asynchronously: state IDLE, pointer 0, counter 0, grant=000, ack=000, disp_data=16'h0000, disp_en=0, busy=0.
REQ-027 Reset asserted mid-SHOW or in DONE SHALL abandon the slot with no ack; after release, arbitration restarts from requester 0.

Verification (DWELL=4)
REQ-028 Reset: hold reset=0 with req=111 -> all outputs zero; release with req=000 -> outputs remain zero, busy=0.
REQ-029 Single request: req=001, req_data0=16'h1234 -> next edge grant=001, disp_data=16'h1234, disp_en=1 for 4 cycles, then ack=001 for 1 cycle, then IDLE.
REQ-030 Fairness: req=111 held, data 16'hAAAA/16'hBBBB/16'hCCCC -> disp_data sequence AAAA, BBBB, CCCC, AAAA with grants 6 cycles apart.
REQ-031 Abort: req=010 granted, then req[1]=0 in the 2nd SHOW cycle -> next edge grant=000, disp_en=0, ack never pulses.
REQ-032 Freeze: freeze=1 for 3 cycles during SHOW -> ack=001 arrives 3 cycles later than in REQ-029; changing req_data0 to 16'h5678 mid-slot leaves disp_data=16'h1234.
REQ-033 Reset mid-SHOW while req=100 granted -> outputs zero immediately; after release with req=101, the first grant is 001.

Source files
------------

// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - request/display bus between requesters and the display arbiter
interface display_arbiter_if;
  logic [2:0]  req;
  logic [15:0] req_data0;
  logic [15:0] req_data1;
  logic [15:0] req_data2;
  logic        freeze;
  logic [2:0]  grant;
  logic [2:0]  ack;
  logic [15:0] disp_data;
  logic        disp_en;
  logic        busy;

  modport master (
    output req, req_data0, req_data1, req_data2, freeze,
    input  grant, ack, disp_data, disp_en, busy
  );

  modport slave (
    input  req, req_data0, req_data1, req_data2, freeze,
    output grant, ack, disp_data, disp_en, busy
  );
endinterface

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin arbiter owning a hex display for a fixed dwell per slot
module display_arbiter #(
  parameter int unsigned DWELL = 1024
) (
  input  logic clk,
  input  logic reset,
  display_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  localparam logic [25:0] LAST = 26'(DWELL - 1);

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  gidx;
  logic [25:0] cnt;
  logic [2:0]  grant_r;
  logic [2:0]  ack_r;
  logic [15:0] data_r;
  logic        en_r;
  logic        busy_r;

  logic [1:0]  sel;
  logic        sel_ok;
  logic [1:0]  cand;
  logic [15:0] sel_data;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search: pointer first, then upward modulo 3
  always_comb begin
    sel    = ptr;
    sel_ok = 1'b0;
    cand   = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!sel_ok && bus.req[cand]) begin
        sel    = cand;
        sel_ok = 1'b1;
      end
      cand = inc3(cand);
    end
  end

  // Data of the requester that would be granted this cycle
  always_comb begin
    sel_data = bus.req_data2;
    case (sel)
      2'd0:    sel_data = bus.req_data0;
      2'd1:    sel_data = bus.req_data1;
      default: sel_data = bus.req_data2;
    endcase
  end

  // Slot FSM; abort is checked before freeze and dwell completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gidx    <= 2'd0;
      cnt     <= '0;
      grant_r <= 3'b000;
      ack_r   <= 3'b000;
      data_r  <= 16'h0000;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ack_r <= 3'b000;
      case (state)
        IDLE: begin
          if (sel_ok) begin
            state   <= SHOW;
            grant_r <= 3'b001 << sel;
            gidx    <= sel;
            data_r  <= sel_data;
            cnt     <= '0;
            en_r    <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        SHOW: begin
          if (!bus.req[gidx]) begin
            state   <= IDLE;
            grant_r <= 3'b000;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            ptr     <= inc3(gidx);
          end else if (!bus.freeze) begin
            if (cnt == LAST) begin
              state   <= DONE;
              grant_r <= 3'b000;
              en_r    <= 1'b0;
              ack_r   <= 3'b001 << gidx;
              ptr     <= inc3(gidx);
            end else begin
              cnt <= cnt + 26'd1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.ack       = ack_r;
  assign bus.disp_data = data_r;
  assign bus.disp_en   = en_r;
  assign bus.busy      = busy_r;
endmodule
